// File: rtl/vend_txn_sequencer_if.sv
// Requester, datapath and status signals between the vending transaction sequencer and its neighbours.
interface vend_txn_sequencer_if #(
    parameter int unsigned MONEY_W = 4,
    parameter int unsigned QTY_W   = 4,
    parameter int unsigned ID_W    = 3,
    parameter int unsigned CNT_W   = 8
) ();
    logic               cust_req;
    logic [MONEY_W-1:0] cust_money;
    logic [ID_W-1:0]    cust_item;
    logic [QTY_W-1:0]   cust_qty;
    logic               cust_ack;
    logic               wd_req;
    logic               wd_ack;
    logic               sup_req;
    logic [ID_W-1:0]    sup_id;
    logic [MONEY_W-1:0] sup_amount;
    logic               sup_ack;
    logic [1:0]         dp_mode;
    logic [MONEY_W-1:0] dp_customer_money;
    logic [ID_W-1:0]    dp_customer_request;
    logic [QTY_W-1:0]   dp_quantity_request;
    logic [ID_W-1:0]    dp_product_id;
    logic [MONEY_W-1:0] dp_amount_added;
    logic               dp_en;
    logic               dp_red_light;
    logic [MONEY_W-1:0] dp_updated_money;
    logic               done;
    logic               err;
    logic [MONEY_W-1:0] change;
    logic [CNT_W-1:0]   txn_count;
    logic [CNT_W-1:0]   err_count;

    // Front panel and datapath side (drives requests and datapath results)
    modport master (
        output cust_req, cust_money, cust_item, cust_qty, wd_req, sup_req, sup_id, sup_amount,
               dp_red_light, dp_updated_money,
        input  cust_ack, wd_ack, sup_ack, dp_mode, dp_customer_money, dp_customer_request,
               dp_quantity_request, dp_product_id, dp_amount_added, dp_en,
               done, err, change, txn_count, err_count
    );

    // Sequencer side
    modport slave (
        input  cust_req, cust_money, cust_item, cust_qty, wd_req, sup_req, sup_id, sup_amount,
               dp_red_light, dp_updated_money,
        output cust_ack, wd_ack, sup_ack, dp_mode, dp_customer_money, dp_customer_request,
               dp_quantity_request, dp_product_id, dp_amount_added, dp_en,
               done, err, change, txn_count, err_count
    );
endinterface

// File: rtl/vend_txn_sequencer.sv
// Arbitrates customer / withdraw / supply requests onto the vending datapath and sequences one commit.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority sup > wd > cust.
module vend_txn_sequencer #(
    parameter int unsigned MONEY_W = 4,
    parameter int unsigned QTY_W   = 4,
    parameter int unsigned ID_W    = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vend_txn_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_COMMIT  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESPOND = 3'd4;

    localparam logic [1:0] M_CUST = 2'b00;
    localparam logic [1:0] M_WD   = 2'b01;
    localparam logic [1:0] M_SUP  = 2'b10;
    localparam logic [1:0] M_IDLE = 2'b11;

    logic [2:0]         state,  state_nxt;
    logic [1:0]         mode,   mode_nxt;
    logic [MONEY_W-1:0] money,  money_nxt;
    logic [ID_W-1:0]    item,   item_nxt;
    logic [QTY_W-1:0]   qty,    qty_nxt;
    logic [ID_W-1:0]    pid,    pid_nxt;
    logic [MONEY_W-1:0] amt,    amt_nxt;
    logic               en,     en_nxt;
    logic [2:0]         ack,    ack_nxt;
    logic               done,   done_nxt;
    logic               err,    err_nxt;
    logic [MONEY_W-1:0] change, change_nxt;
    logic [CNT_W-1:0]   txn,    txn_nxt;
    logic [CNT_W-1:0]   errc,   errc_nxt;

    logic [2:0] req_c;
    logic [1:0] win_c;

    assign req_c = {bus.sup_req, bus.wd_req, bus.cust_req};

`ifdef ARB_RR_EN
    logic [1:0] last;

    // Search starts just after the last-granted requester
    always_comb begin
        win_c = M_CUST;
        case (last)
            M_CUST:  win_c = req_c[1] ? M_WD   : (req_c[2] ? M_SUP  : M_CUST);
            M_WD:    win_c = req_c[2] ? M_SUP  : (req_c[0] ? M_CUST : M_WD);
            default: win_c = req_c[0] ? M_CUST : (req_c[1] ? M_WD   : M_SUP);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= M_SUP;
        end else if (state == S_IDLE && |req_c) begin
            last <= win_c;
        end
    end
`else
    always_comb begin
        win_c = M_CUST;
        if (req_c[2])      win_c = M_SUP;
        else if (req_c[1]) win_c = M_WD;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mode   <= M_IDLE;
            money  <= '0;
            item   <= '0;
            qty    <= '0;
            pid    <= '0;
            amt    <= '0;
            en     <= 1'b0;
            ack    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            change <= '0;
            txn    <= '0;
            errc   <= '0;
        end else begin
            state  <= state_nxt;
            mode   <= mode_nxt;
            money  <= money_nxt;
            item   <= item_nxt;
            qty    <= qty_nxt;
            pid    <= pid_nxt;
            amt    <= amt_nxt;
            en     <= en_nxt;
            ack    <= ack_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
            change <= change_nxt;
            txn    <= txn_nxt;
            errc   <= errc_nxt;
        end
    end

    // Next-state and next-output logic; every output is registered one state ahead
    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode;
        money_nxt  = money;
        item_nxt   = item;
        qty_nxt    = qty;
        pid_nxt    = pid;
        amt_nxt    = amt;
        en_nxt     = 1'b0;
        ack_nxt    = '0;
        done_nxt   = 1'b0;
        err_nxt    = err;
        change_nxt = change;
        txn_nxt    = txn;
        errc_nxt   = errc;
        case (state)
            S_IDLE: begin
                if (|req_c) begin
                    state_nxt = S_SETUP;
                    mode_nxt  = win_c;
                    if (win_c == M_CUST) begin
                        money_nxt = bus.cust_money;
                        item_nxt  = bus.cust_item;
                        qty_nxt   = bus.cust_qty;
                    end
                    if (win_c == M_SUP) begin
                        pid_nxt = bus.sup_id;
                        amt_nxt = bus.sup_amount;
                    end
                end
            end
            S_SETUP: begin
                state_nxt = S_COMMIT;
                en_nxt    = 1'b1;
                txn_nxt   = txn + CNT_W'(1);
            end
            S_COMMIT: begin
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt  = S_RESPOND;
                err_nxt    = bus.dp_red_light;
                change_nxt = bus.dp_updated_money;
                if (bus.dp_red_light && errc != '1) errc_nxt = errc + CNT_W'(1);
                ack_nxt    = 3'b001 << mode;
                done_nxt   = 1'b1;
            end
            S_RESPOND: begin
                state_nxt = S_IDLE;
                mode_nxt  = M_IDLE;
                money_nxt = '0;
                item_nxt  = '0;
                qty_nxt   = '0;
                pid_nxt   = '0;
                amt_nxt   = '0;
                err_nxt   = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.dp_mode             = mode;
    assign bus.dp_customer_money   = money;
    assign bus.dp_customer_request = item;
    assign bus.dp_quantity_request = qty;
    assign bus.dp_product_id       = pid;
    assign bus.dp_amount_added     = amt;
    assign bus.dp_en               = en;
    assign bus.cust_ack            = ack[0];
    assign bus.wd_ack              = ack[1];
    assign bus.sup_ack             = ack[2];
    assign bus.done                = done;
    assign bus.err                 = err;
    assign bus.change              = change;
    assign bus.txn_count           = txn;
    assign bus.err_count           = errc;
endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Bench for vend_txn_sequencer: transaction-level reference model, per-cycle compare, directed and random stimulus.
module tb_vend_txn_sequencer;
    localparam int unsigned MONEY_W = 4;
    localparam int unsigned QTY_W   = 4;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned CNT_W   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    vend_txn_sequencer_if #(.MONEY_W(MONEY_W), .QTY_W(QTY_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    vend_txn_sequencer #(.MONEY_W(MONEY_W), .QTY_W(QTY_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Reference model: one transaction at a time, tracked by edges elapsed since its grant
    bit                 m_busy   = 1'b0;
    int                 m_k      = 0;
    int                 m_win    = 3;
    int                 m_last   = 2;
    logic [MONEY_W-1:0] m_money  = '0;
    logic [ID_W-1:0]    m_item   = '0;
    logic [QTY_W-1:0]   m_qty    = '0;
    logic [ID_W-1:0]    m_pid    = '0;
    logic [MONEY_W-1:0] m_amt    = '0;
    logic               m_err    = 1'b0;
    logic [MONEY_W-1:0] m_change = '0;
    logic [CNT_W-1:0]   m_txn    = '0;
    logic [CNT_W-1:0]   m_errc   = '0;

    function automatic int pick(input logic [2:0] r, input int last);
        int w;
        w = 3;
`ifdef ARB_RR_EN
        for (int i = 1; i <= 3; i++) begin
            if (w == 3 && r[(last + i) % 3]) w = (last + i) % 3;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (r[i]) w = i;
        end
`endif
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_k = 0; m_win = 3; m_last = 2;
            m_money = '0; m_item = '0; m_qty = '0; m_pid = '0; m_amt = '0;
            m_err = 1'b0; m_change = '0; m_txn = '0; m_errc = '0;
        end else if (m_busy) begin
            m_k++;
            if (m_k == 1) m_txn = m_txn + 8'd1;
            if (m_k == 3) begin
                m_err    = bus.dp_red_light;
                m_change = bus.dp_updated_money;
                if (bus.dp_red_light && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
            end
            if (m_k == 4) begin
                m_busy = 1'b0; m_win = 3; m_err = 1'b0;
                m_money = '0; m_item = '0; m_qty = '0; m_pid = '0; m_amt = '0;
            end
        end else if (bus.cust_req || bus.wd_req || bus.sup_req) begin
            m_win  = pick({bus.sup_req, bus.wd_req, bus.cust_req}, m_last);
            m_last = m_win;
            m_busy = 1'b1;
            m_k    = 0;
            if (m_win == 0) begin
                m_money = bus.cust_money; m_item = bus.cust_item; m_qty = bus.cust_qty;
            end
            if (m_win == 2) begin
                m_pid = bus.sup_id; m_amt = bus.sup_amount;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic resp;
        resp = m_busy && m_k == 3;
        chk("dp_mode",   32'(bus.dp_mode), 32'(m_win));
        chk("dp_money",  32'(bus.dp_customer_money), 32'(m_money));
        chk("dp_item",   32'(bus.dp_customer_request), 32'(m_item));
        chk("dp_qty",    32'(bus.dp_quantity_request), 32'(m_qty));
        chk("dp_pid",    32'(bus.dp_product_id), 32'(m_pid));
        chk("dp_amt",    32'(bus.dp_amount_added), 32'(m_amt));
        chk("dp_en",     32'(bus.dp_en), 32'(m_busy && m_k == 1));
        chk("cust_ack",  32'(bus.cust_ack), 32'(resp && m_win == 0));
        chk("wd_ack",    32'(bus.wd_ack), 32'(resp && m_win == 1));
        chk("sup_ack",   32'(bus.sup_ack), 32'(resp && m_win == 2));
        chk("done",      32'(bus.done), 32'(resp));
        chk("err",       32'(bus.err), 32'(m_err));
        chk("change",    32'(bus.change), 32'(m_change));
        chk("txn_count", 32'(bus.txn_count), 32'(m_txn));
        chk("err_count", 32'(bus.err_count), 32'(m_errc));
    end

    // One clock; requesters drop their request right after seeing their ack
    task automatic cycle();
        @(posedge clk);
        #1;
        if (bus.cust_ack) bus.cust_req = 1'b0;
        if (bus.wd_ack)   bus.wd_req   = 1'b0;
        if (bus.sup_ack)  bus.sup_req  = 1'b0;
    endtask

    task automatic do_reset();
        bus.cust_req = 1'b0; bus.wd_req = 1'b0; bus.sup_req = 1'b0;
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp1, exp2;
        bus.cust_req = 1'b0; bus.cust_money = '0; bus.cust_item = '0; bus.cust_qty = '0;
        bus.wd_req = 1'b0; bus.sup_req = 1'b0; bus.sup_id = '0; bus.sup_amount = '0;
        bus.dp_red_light = 1'b0; bus.dp_updated_money = '0;

        // Reset, then quiet idle
        do_reset();
        chk("rst_txn_count", 32'(bus.txn_count), 0);
        chk("rst_err_count", 32'(bus.err_count), 0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("idle_mode", 32'(bus.dp_mode), 3);
            chk("idle_acks", 32'({bus.cust_ack, bus.wd_ack, bus.sup_ack, bus.dp_en}), 0);
        end

        // Customer purchase, no error
        bus.cust_req = 1'b1; bus.cust_money = 4'd6; bus.cust_item = 3'd7; bus.cust_qty = 4'd1;
        bus.dp_red_light = 1'b0; bus.dp_updated_money = 4'd2;
        cycle();
        chk("t2_mode", 32'(bus.dp_mode), 0);
        chk("t2_money", 32'(bus.dp_customer_money), 6);
        chk("t2_item", 32'(bus.dp_customer_request), 7);
        cycle();
        chk("t2_dp_en", 32'(bus.dp_en), 1);
        chk("t2_txn", 32'(bus.txn_count), 1);
        cycle();
        cycle();
        chk("t2_ack_done", 32'({bus.cust_ack, bus.done}), 3);
        chk("t2_err", 32'(bus.err), 0);
        chk("t2_change", 32'(bus.change), 2);
        cycle();
        chk("t2_back_idle", 32'(bus.dp_mode), 3);

        // Customer purchase with datapath error
        bus.cust_req = 1'b1; bus.cust_money = 4'd14; bus.cust_item = 3'd1; bus.cust_qty = 4'd2;
        bus.dp_red_light = 1'b1; bus.dp_updated_money = 4'd5;
        repeat (4) cycle();
        chk("t3_err_done", 32'({bus.err, bus.done, bus.cust_ack}), 7);
        chk("t3_err_count", 32'(bus.err_count), 1);
        chk("t3_other_acks", 32'({bus.wd_ack, bus.sup_ack}), 0);
        chk("t3_txn", 32'(bus.txn_count), 2);
        cycle();

        // Supply and withdraw together, then both re-raised
`ifdef ARB_RR_EN
        exp1 = 3'b010; exp2 = 3'b100;
`else
        exp1 = 3'b100; exp2 = 3'b100;
`endif
        bus.dp_red_light = 1'b0;
        bus.sup_req = 1'b1; bus.sup_id = 3'd1; bus.sup_amount = 4'd13; bus.wd_req = 1'b1;
        repeat (4) cycle();
        chk("t4_first", 32'({bus.sup_ack, bus.wd_ack, bus.cust_ack}), 32'(exp1));
        bus.sup_req = 1'b1; bus.wd_req = 1'b1;
        repeat (5) cycle();
        chk("t4_second", 32'({bus.sup_ack, bus.wd_ack, bus.cust_ack}), 32'(exp2));
        bus.sup_req = 1'b0; bus.wd_req = 1'b0;
        cycle();
        cycle();
        chk("t4_idle", 32'(bus.dp_mode), 3);

        // Reset while dp_en is high
        bus.cust_req = 1'b1;
        cycle();
        cycle();
        chk("t5_dp_en_before", 32'(bus.dp_en), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_dp_en", 32'(bus.dp_en), 0);
        chk("t5_mode", 32'(bus.dp_mode), 3);
        chk("t5_counts", 32'({bus.txn_count, bus.err_count}), 0);
        bus.cust_req = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t5_no_ack", 32'({bus.cust_ack, bus.done}), 0);
        end

        // Counter wrap and error saturation over 256 transactions
        do_reset();
        bus.dp_red_light = 1'b1;
        bus.cust_req = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            int t;
            t = 0;
            do begin
                bus.dp_updated_money = 4'($urandom);
                cycle();
                t++;
            end while (!bus.cust_ack && t < 10);
            if (!bus.cust_ack) begin
                chk("t6_ack_timeout", 32'(bus.cust_ack), 1);
                break;
            end
            if (n == 255) begin
                chk("t6_txn_255", 32'(bus.txn_count), 255);
                chk("t6_err_255", 32'(bus.err_count), 255);
            end
            if (n == 256) begin
                chk("t6_txn_wrap", 32'(bus.txn_count), 0);
                chk("t6_err_sat", 32'(bus.err_count), 255);
            end
            bus.cust_req = (n < 256);
        end
        repeat (3) cycle();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            bus.cust_money = 4'($urandom); bus.cust_item = 3'($urandom); bus.cust_qty = 4'($urandom);
            bus.sup_id = 3'($urandom); bus.sup_amount = 4'($urandom);
            bus.dp_red_light = 1'($urandom); bus.dp_updated_money = 4'($urandom);
            if (!bus.cust_req) bus.cust_req = ($urandom_range(0, 3) == 0);
            else if (!(m_busy && m_win == 0) && $urandom_range(0, 31) == 0) bus.cust_req = 1'b0;
            if (!bus.wd_req) bus.wd_req = ($urandom_range(0, 5) == 0);
            else if (!(m_busy && m_win == 1) && $urandom_range(0, 31) == 0) bus.wd_req = 1'b0;
            if (!bus.sup_req) bus.sup_req = ($urandom_range(0, 5) == 0);
            else if (!(m_busy && m_win == 2) && $urandom_range(0, 31) == 0) bus.sup_req = 1'b0;
            cycle();
        end
        bus.cust_req = 1'b0; bus.wd_req = 1'b0; bus.sup_req = 1'b0;
        repeat (6) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
